// File: rtl/ram_pkg.sv
// Shared types, latency constants and the byte-merge helper for the single-port RAM.
package ram_pkg;

    typedef enum logic [0:0] {StInit, StRun} ram_state_e;

    localparam int unsigned RdLatMin = 1;
    localparam int unsigned RdLatMax = 2;

    // Widest data word the merge helper supports; callers size-cast to/from their own width.
    localparam int unsigned MaxDw = 512;
    localparam int unsigned MaxBw = MaxDw / 8;

    function automatic logic [MaxDw-1:0] byte_merge(input logic [MaxDw-1:0] old_data,
                                                    input logic [MaxDw-1:0] new_data,
                                                    input logic [MaxBw-1:0] be);
        logic [MaxDw-1:0] res;
        res = old_data;
        for (int i = 0; i < int'(MaxBw); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Inferred DEPTH x DW storage with per-byte write enables and a registered read port.
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DW/8-1:0] we_be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic            rd_en,
    input  logic            rd_clr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    // Storage itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (|we_be) begin
            mem[addr] <= DW'(byte_merge(MaxDw'(mem[addr]), MaxDw'(wdata), MaxBw'(we_be)));
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_clr) begin
            rdata_d = '0;
        end else if (rd_en) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: zero-fill FSM, request handling, range check and read pipeline.
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            init_done
);

    localparam int unsigned BW      = DW / 8;
    localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LastCnt = (AW+1)'(DEPTH - 1);

    ram_state_e    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          v1_q, v1_d;
    logic          err1_q, err1_d;

    logic          accept;
    logic          in_range;
    logic [BW-1:0] arr_be;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;
    logic          arr_rd_en;
    logic          arr_rd_clr;
    logic [DW-1:0] arr_rdata;

    always_comb begin
        accept     = req_valid && ready_q;
        in_range   = {1'b0, req_addr} < DepthW;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        done_d     = done_q;
        arr_be     = '0;
        arr_addr   = req_addr;
        arr_wdata  = req_wdata;
        arr_rd_en  = 1'b0;
        arr_rd_clr = 1'b0;
        unique case (state_q)
            StInit: begin
                arr_be    = '1;
                arr_addr  = cnt_q[AW-1:0];
                arr_wdata = '0;
                cnt_d     = cnt_q + {{AW{1'b0}}, 1'b1};
                if (cnt_q == LastCnt) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                if (accept && req_we && in_range) begin
                    arr_be = req_be;
                end
                arr_rd_en  = accept && !req_we && in_range;
                arr_rd_clr = accept && !req_we && !in_range;
            end
            default: state_d = StInit;
        endcase
        v1_d   = accept && !req_we;
        err1_d = v1_d && !in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            v1_q    <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            v1_q    <= v1_d;
            err1_q  <= err1_d;
        end
    end

    ram_sp_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we_be   (arr_be),
        .addr    (arr_addr),
        .wdata   (arr_wdata),
        .rd_en   (arr_rd_en),
        .rd_clr  (arr_rd_clr),
        .rdata   (arr_rdata)
    );

    assign req_ready = ready_q;
    assign init_done = done_q;

    if (RD_LAT <= RdLatMin) begin : g_lat1
        assign rsp_valid = v1_q;
        assign rsp_err   = err1_q;
        assign rsp_rdata = arr_rdata;
    end else begin : g_lat2
        logic          v2_q;
        logic          err2_q;
        logic [DW-1:0] rdata2_q, rdata2_d;

        // Output register only loads when a response moves through, so data holds between pulses.
        always_comb begin
            rdata2_d = v1_q ? arr_rdata : rdata2_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2_q     <= 1'b0;
                err2_q   <= 1'b0;
                rdata2_q <= '0;
            end else begin
                v2_q     <= v1_q;
                err2_q   <= err1_q;
                rdata2_q <= rdata2_d;
            end
        end

        assign rsp_valid = v2_q;
        assign rsp_err   = err2_q;
        assign rsp_rdata = rdata2_q;
    end

endmodule
